// File: rtl/fc_layer_seq_pkg.sv
// Shared definitions for the fully-connected layer sequencer: FSM encoding,
// the floating-point zero word and the address-width helper.
package fc_layer_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_ACC,
        S_DRAIN,
        S_CAP,
        S_DONE
    } fc_state_e;

    localparam logic [31:0] FP_ZERO = 32'h0000_0000;

    // Address width for an n-entry memory, never below one bit.
    function automatic int fc_aw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fc_addr_gen.sv
// Input/weight address generation for the FC sequencer: per-neuron k counter,
// output-column counter and a free-running weight address counter.
module fc_addr_gen
    import fc_layer_seq_pkg::*;
#(
    parameter int N_IN   = 16,
    parameter int N_OUT  = 10,
    parameter int IN_AW  = 4,
    parameter int W_AW   = 8,
    parameter int OUT_AW = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  fc_state_e         state_i,
    input  logic              layer_start_i,
    input  logic              col_adv_i,
    output logic              issue_o,
    output logic [IN_AW-1:0]  in_addr_o,
    output logic [W_AW-1:0]   w_addr_o,
    output logic [OUT_AW-1:0] col_o,
    output logic              k_last_o,
    output logic              col_last_o
);

    localparam logic [IN_AW-1:0]  K_LAST   = IN_AW'(N_IN - 1);
    localparam logic [OUT_AW-1:0] COL_LAST = OUT_AW'(N_OUT - 1);

    logic [IN_AW-1:0]  k_q,   k_d;
    logic [OUT_AW-1:0] col_q, col_d;
    logic [W_AW-1:0]   w_q,   w_d;

    assign issue_o    = (state_i == S_CLR) || (state_i == S_ACC);
    assign in_addr_o  = (state_i == S_CLR) ? '0 : k_q;
    assign w_addr_o   = w_q;
    assign col_o      = col_q;
    assign k_last_o   = (k_q == K_LAST);
    assign col_last_o = (col_q == COL_LAST);

    // The weight counter only restarts with a new layer: consecutive columns
    // are contiguous in weight memory, so col*N_IN+k needs no multiplier.
    always_comb begin
        k_d   = k_q;
        col_d = col_q;
        w_d   = w_q;
        if (state_i == S_CLR)
            k_d = IN_AW'(1);
        else if (state_i == S_ACC)
            k_d = k_q + IN_AW'(1);
        if (layer_start_i)
            col_d = '0;
        else if (col_adv_i)
            col_d = col_q + OUT_AW'(1);
        if (layer_start_i)
            w_d = '0;
        else if (issue_o)
            w_d = w_q + W_AW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            k_q   <= '0;
            col_q <= '0;
            w_q   <= '0;
        end else begin
            k_q   <= k_d;
            col_q <= col_d;
            w_q   <= w_d;
        end
    end

endmodule

// File: rtl/fc_layer_seq.sv
// Sequencer for one fully-connected layer: streams input/weight pairs into an
// external FP multiply-accumulate PE and hands each neuron sum downstream.
module fc_layer_seq
    import fc_layer_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int N_IN       = 16,
    parameter int N_OUT      = 10,
    parameter int IN_AW      = fc_aw(N_IN),
    parameter int W_AW       = fc_aw(N_IN * N_OUT),
    parameter int OUT_AW     = fc_aw(N_OUT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_en,
    output logic [IN_AW-1:0]      in_addr,
    output logic [W_AW-1:0]       w_addr,
    input  logic [DATA_WIDTH-1:0] in_rdata,
    input  logic [DATA_WIDTH-1:0] w_rdata,
    output logic [DATA_WIDTH-1:0] pe_input,
    output logic [DATA_WIDTH-1:0] pe_weight,
    output logic                  pe_start_newcol,
    input  logic [DATA_WIDTH-1:0] pe_output,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic [OUT_AW-1:0]     res_idx,
    output logic                  res_valid,
    input  logic                  res_ready
);

    fc_state_e             state_q, state_d;
    logic                  rd_valid_q;
    logic [DATA_WIDTH-1:0] res_data_q;
    logic [OUT_AW-1:0]     res_idx_q;
    logic                  res_valid_q;

    logic                  layer_start, cap_fire, col_adv;
    logic                  k_last, col_last;
    logic [OUT_AW-1:0]     col;

    assign layer_start = (state_q == S_IDLE) && start;
    assign cap_fire    = (state_q == S_CAP) && (!res_valid_q || res_ready);
    assign col_adv     = cap_fire && !col_last;

    fc_addr_gen #(
        .N_IN   (N_IN),
        .N_OUT  (N_OUT),
        .IN_AW  (IN_AW),
        .W_AW   (W_AW),
        .OUT_AW (OUT_AW)
    ) u_addr_gen (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .state_i       (state_q),
        .layer_start_i (layer_start),
        .col_adv_i     (col_adv),
        .issue_o       (mem_rd_en),
        .in_addr_o     (in_addr),
        .w_addr_o      (w_addr),
        .col_o         (col),
        .k_last_o      (k_last),
        .col_last_o    (col_last)
    );

    // The PE accumulates every clock, so non-data cycles must feed 0*0.
    assign pe_input  = rd_valid_q ? in_rdata : DATA_WIDTH'(FP_ZERO);
    assign pe_weight = rd_valid_q ? w_rdata  : DATA_WIDTH'(FP_ZERO);

    assign res_data  = res_data_q;
    assign res_idx   = res_idx_q;
    assign res_valid = res_valid_q;

    always_comb begin
        state_d         = state_q;
        busy            = (state_q != S_IDLE);
        done            = 1'b0;
        pe_start_newcol = 1'b0;
        case (state_q)
            S_IDLE:  if (start) state_d = S_CLR;
            S_CLR: begin
                pe_start_newcol = 1'b1;
                state_d         = (N_IN == 1) ? S_DRAIN : S_ACC;
            end
            S_ACC:   if (k_last) state_d = S_DRAIN;
            S_DRAIN: state_d = S_CAP;
            S_CAP:   if (cap_fire) state_d = col_last ? S_DONE : S_CLR;
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rd_valid_q  <= 1'b0;
            res_data_q  <= '0;
            res_idx_q   <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_valid_q <= mem_rd_en;
            // A capture in the same cycle as a hand-off keeps valid asserted.
            if (cap_fire) begin
                res_data_q  <= pe_output;
                res_idx_q   <= col;
                res_valid_q <= 1'b1;
            end else if (res_ready) begin
                res_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fc_layer_seq.sv
// Directed bench for fc_layer_seq with a behavioural FP MAC PE and memories.
module tb_fc_layer_seq;

    logic clk, rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance A: N_IN=4, N_OUT=3 ----------------
    logic        startA, busyA, doneA, rdA, ncA, resA_valid, readyA;
    logic [1:0]  inaddrA, resA_idx;
    logic [3:0]  waddrA;
    logic [31:0] inrdA, wrdA, pinA, pwA, poutA, resA_data;

    fc_layer_seq #(.DATA_WIDTH(32), .N_IN(4), .N_OUT(3)) dutA (
        .clk(clk), .rst_n(rst_n), .start(startA), .busy(busyA), .done(doneA),
        .mem_rd_en(rdA), .in_addr(inaddrA), .w_addr(waddrA),
        .in_rdata(inrdA), .w_rdata(wrdA), .pe_input(pinA), .pe_weight(pwA),
        .pe_start_newcol(ncA), .pe_output(poutA), .res_data(resA_data),
        .res_idx(resA_idx), .res_valid(resA_valid), .res_ready(readyA)
    );

    // ---------------- instance B: N_IN=1, N_OUT=1 ----------------
    logic        startB, busyB, doneB, rdB, ncB, resB_valid;
    logic [0:0]  inaddrB, waddrB, resB_idx;
    logic [31:0] inrdB, wrdB, pinB, pwB, poutB, resB_data;

    fc_layer_seq #(.DATA_WIDTH(32), .N_IN(1), .N_OUT(1)) dutB (
        .clk(clk), .rst_n(rst_n), .start(startB), .busy(busyB), .done(doneB),
        .mem_rd_en(rdB), .in_addr(inaddrB), .w_addr(waddrB),
        .in_rdata(inrdB), .w_rdata(wrdB), .pe_input(pinB), .pe_weight(pwB),
        .pe_start_newcol(ncB), .pe_output(poutB), .res_data(resB_data),
        .res_idx(resB_idx), .res_valid(resB_valid), .res_ready(1'b1)
    );

    // ---------------- single-precision helpers (normal numbers only) ----------------
    function automatic real f2r(input logic [31:0] b);
        real r;
        int  e;
        if (b[30:23] == 8'd0) return 0.0;
        r = $itor({8'd0, 1'b1, b[22:0]});
        e = int'(b[30:23]) - 150;
        while (e > 0) begin r = r * 2.0; e--; end
        while (e < 0) begin r = r / 2.0; e++; end
        return b[31] ? -r : r;
    endfunction

    function automatic logic [31:0] r2f(input real v);
        real         a;
        int          e;
        logic [31:0] fr;
        if (v == 0.0) return 32'h0;
        a = (v < 0.0) ? -v : v;
        e = 127;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0)  begin a = a * 2.0; e--; end
        fr = 32'($rtoi((a - 1.0) * 8388608.0));
        return {(v < 0.0), e[7:0], fr[22:0]};
    endfunction

    // ---------------- memories (garbage when not read) and PE models ----------------
    logic [31:0] in_mem [4];
    logic [31:0] w_mem  [12];
    initial begin
        in_mem[0] = 32'h3F80_0000; in_mem[1] = 32'h4000_0000;
        in_mem[2] = 32'h4040_0000; in_mem[3] = 32'h4080_0000;
        for (int i = 0; i < 12; i++)
            w_mem[i] = (i < 4) ? 32'h3F80_0000 : (i < 8) ? 32'h4000_0000 : 32'h0;
    end

    always @(posedge clk) begin
        inrdA <= rdA ? in_mem[inaddrA] : 32'hDEAD_BEEF;
        wrdA  <= rdA ? w_mem[waddrA]   : 32'hDEAD_BEEF;
        inrdB <= (rdB && inaddrB == 1'b0) ? 32'h4040_0000 : 32'hDEAD_BEEF;
        wrdB  <= (rdB && waddrB == 1'b0)  ? 32'h4000_0000 : 32'hDEAD_BEEF;
    end

    real accA = 0.0, accB = 0.0;
    always @(posedge clk) begin
        accA <= (ncA ? 0.0 : accA) + f2r(pinA) * f2r(pwA);
        accB <= (ncB ? 0.0 : accB) + f2r(pinB) * f2r(pwB);
    end
    assign poutA = r2f(accA);
    assign poutB = r2f(accB);

    // ---------------- instance A observer ----------------
    int          n_res, n_done, n_newcol, n_issue, w_err, nz_err, nc_err;
    logic [3:0]  w_exp;
    logic        prev_rd = 1'b0;
    logic [31:0] res_d [8];
    logic [1:0]  res_i [8];

    always @(negedge clk) begin
        prev_rd <= rdA;
        if (startA && !busyA) begin
            n_res <= 0; n_done <= 0; n_newcol <= 0; n_issue <= 0;
            w_err <= 0; nz_err <= 0; nc_err <= 0; w_exp <= 4'd0;
        end else begin
            if (!prev_rd && (pinA != 32'h0 || pwA != 32'h0)) nz_err <= nz_err + 1;
            if (rdA) begin
                n_issue <= n_issue + 1;
                w_exp   <= w_exp + 4'd1;
                if (waddrA != w_exp || inaddrA != w_exp[1:0]) w_err <= w_err + 1;
            end
            if (ncA) begin
                n_newcol <= n_newcol + 1;
                if (!rdA || inaddrA != 2'd0 || waddrA[1:0] != 2'd0) nc_err <= nc_err + 1;
            end
            if (resA_valid && readyA) begin
                if (n_res < 8) begin
                    res_d[n_res] <= resA_data;
                    res_i[n_res] <= resA_idx;
                end
                n_res <= n_res + 1;
            end
            if (doneA) n_done <= n_done + 1;
        end
    end

    // ---------------- checking ----------------
    int checks = 0, errors = 0;
    logic [31:0] exp_sum [3];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_layer(input string t);
        chk({t, "_nres"}, 32'(n_res), 32'd3);
        for (int k = 0; k < 3; k++) begin
            chk({t, "_idx"}, 32'(res_i[k]), 32'(k));
            chk({t, "_sum"}, res_d[k], exp_sum[k]);
        end
        chk({t, "_ndone"},  32'(n_done),   32'd1);
        chk({t, "_newcol"}, 32'(n_newcol), 32'd3);
        chk({t, "_issue"},  32'(n_issue),  32'd12);
        chk({t, "_waddr"},  32'(w_err),    32'd0);
        chk({t, "_opzero"}, 32'(nz_err),   32'd0);
        chk({t, "_ncslot"}, 32'(nc_err),   32'd0);
        chk({t, "_idle"},   32'(busyA),    32'd0);
    endtask

    // Start layer A and run until done; optionally pokes start while busy.
    task automatic run_a(input bit poke, output int lat);
        int cnt;
        cnt = 0;
        lat = 0;
        startA = 1'b1;
        while (cnt < 200 && !doneA) begin
            @(posedge clk); #1;
            cnt++;
            startA = poke && (cnt == 3);
            if (resA_valid && lat == 0) lat = cnt;
        end
        startA = 1'b0;
        chk("a_done_seen", 32'(doneA), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        int lat, cnt;
        logic [31:0] bdata;
        logic        brd1, brd2, bnc1, bnc2;
        exp_sum[0] = 32'h4120_0000;
        exp_sum[1] = 32'h41A0_0000;
        exp_sum[2] = 32'h0000_0000;
        rst_n = 1'b0; startA = 1'b0; startB = 1'b0; readyA = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",  32'(busyA),      32'd0);
        chk("rst_valid", 32'(resA_valid), 32'd0);
        chk("rst_data",  resA_data,       32'd0);
        chk("rst_idx",   32'(resA_idx),   32'd0);
        chk("rst_done",  32'(doneA),      32'd0);
        chk("rst_rd",    32'(rdA),        32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Layer 1: free-flowing, extra start pulse while busy
        run_a(1'b1, lat);
        chk("l1_latency", 32'(lat), 32'd7);
        check_layer("l1");

        // Layer 2: backpressure from the first result
        readyA = 1'b0;
        startA = 1'b1;
        @(posedge clk); #1;
        startA = 1'b0;
        repeat (19) begin @(posedge clk); #1; end
        chk("bp_valid", 32'(resA_valid), 32'd1);
        chk("bp_data",  resA_data,       32'h4120_0000);
        chk("bp_idx",   32'(resA_idx),   32'd0);
        chk("bp_busy",  32'(busyA),      32'd1);
        chk("bp_park",  32'(rdA),        32'd0);
        chk("bp_nres",  32'(n_res),      32'd0);
        readyA = 1'b1;
        @(posedge clk); #1;
        chk("bp_load_data",  resA_data,       32'h41A0_0000);
        chk("bp_load_idx",   32'(resA_idx),   32'd1);
        chk("bp_load_valid", 32'(resA_valid), 32'd1);
        cnt = 0;
        while (cnt < 200 && !doneA) begin @(posedge clk); #1; cnt++; end
        chk("bp_done_seen", 32'(doneA), 32'd1);
        @(posedge clk); #1;
        check_layer("l2");

        // Layer 3: reset during ACC of column 1 (result 0 held, not taken)
        readyA = 1'b0;
        startA = 1'b1;
        @(posedge clk); #1;
        startA = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        chk("mid_rd",    32'(rdA),        32'd1);
        chk("mid_valid", 32'(resA_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy",  32'(busyA),      32'd0);
        chk("mid_rst_valid", 32'(resA_valid), 32'd0);
        chk("mid_rst_rd",    32'(rdA),        32'd0);
        chk("mid_rst_data",  resA_data,       32'd0);
        chk("mid_rst_nres",  32'(n_res),      32'd0);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        readyA = 1'b1;
        @(posedge clk); #1;

        // Layer 4: clean restart after the abandoned layer
        run_a(1'b0, lat);
        chk("l4_latency", 32'(lat), 32'd7);
        check_layer("l4");

        // Instance B: single input, single output
        startB = 1'b1;
        cnt = 0; lat = 0; bdata = 32'h0;
        brd1 = 1'b0; brd2 = 1'b1; bnc1 = 1'b0; bnc2 = 1'b1;
        while (cnt < 50 && !doneB) begin
            @(posedge clk); #1;
            cnt++;
            startB = 1'b0;
            if (cnt == 1) begin brd1 = rdB; bnc1 = ncB; end
            if (cnt == 2) begin brd2 = rdB; bnc2 = ncB; end
            if (resB_valid && lat == 0) begin lat = cnt; bdata = resB_data; end
        end
        chk("b_clr_rd",  32'(brd1),     32'd1);
        chk("b_clr_nc",  32'(bnc1),     32'd1);
        chk("b_drain_rd", 32'(brd2),    32'd0);
        chk("b_drain_nc", 32'(bnc2),    32'd0);
        chk("b_latency", 32'(lat),      32'd4);
        chk("b_data",    bdata,         32'h40C0_0000);
        chk("b_idx",     32'(resB_idx), 32'd0);
        chk("b_done",    32'(doneB),    32'd1);
        @(posedge clk); #1;
        chk("b_idle",    32'(busyB),    32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fc_layer_seq.md
Name: fc_layer_seq

Overview:
- Sequencer for one fully-connected layer built around the floating-point multiply-accumulate PE (PE_FC_ANN-style: fpmul + fp_add, accumulator cleared by start_newcol).
- For each output neuron it walks all N_IN inputs, reads the input buffer and weight memory, feeds gated operands to the PE, then captures the finished sum into a result register with valid/ready handshake.
- Sits between the layer's input/weight memories, a single PE instance and the next layer's writer.

Parameters:
- DATA_WIDTH, 32, IEEE-754 single word width.
- N_IN, 16, inputs per neuron (>=1).
- N_OUT, 10, output neurons (>=1).
- IN_AW, $clog2(N_IN) (min 1), input buffer address width.
- W_AW, $clog2(N_IN*N_OUT) (min 1), weight memory address width.
- OUT_AW, $clog2(N_OUT) (min 1), result index width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle start pulse; ignored unless IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last result is accepted into the result register.
- mem_rd_en  out  1  read strobe to both memories.
- in_addr  out  IN_AW  input buffer address.
- w_addr  out  W_AW  weight address = col*N_IN + k.
- in_rdata  in  DATA_WIDTH  input data, valid 1 cycle after mem_rd_en.
- w_rdata  in  DATA_WIDTH  weight data, valid 1 cycle after mem_rd_en.
- pe_input  out  DATA_WIDTH  to PE input_fc.
- pe_weight  out  DATA_WIDTH  to PE iweight_FC.
- pe_start_newcol  out  1  to PE start_newcol.
- pe_output  in  DATA_WIDTH  from PE output_fc.
- res_data  out  DATA_WIDTH  captured neuron sum.
- res_idx  out  OUT_AW  neuron index of res_data.
- res_valid  out  1  result handshake valid.
- res_ready  in  1  result handshake ready.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; col, k, weight counter = 0; rd_valid_d = 0; res_valid = 0; res_data = 0; res_idx = 0; done = 0. Reset mid-layer abandons the layer; no partial result is emitted.
- mem_rd_en, addresses and pe_start_newcol are registered or state-decoded with no combinational path from inputs.
- pe_input/pe_weight = in_rdata/w_rdata when rd_valid_d (mem_rd_en delayed 1 cycle), else 32'h0. The PE accumulates every clock, so invalid cycles must add 0*0.
- FSM states:
  - IDLE: start -> CLR with col=0.
  - CLR: pe_start_newcol=1; mem_rd_en=1; in_addr=0; w_addr=col*N_IN; k<=1. If N_IN==1 -> DRAIN, else -> ACC.
  - ACC: mem_rd_en=1; in_addr=k; w_addr=col*N_IN+k; k++. After issuing k=N_IN-1 -> DRAIN.
  - DRAIN: no issue. The last operand pair is accumulated at the end of this cycle. -> CAP.
  - CAP: pe_output is the final sum. If !res_valid or res_ready: res_data<=pe_output, res_idx<=col, res_valid<=1. Then if col==N_OUT-1 -> DONE, else col++ and -> CLR. Otherwise stay in CAP; zero operands keep the PE sum unchanged.
  - DONE: done=1 for one cycle -> IDLE.
- Result handshake:
  - res_valid clears on res_valid&&res_ready unless a new capture occurs in the same cycle; in that case res_valid stays 1 and new data is loaded.
  - res_data/res_idx stay stable while res_valid&&!res_ready.
- Throughput: N_IN+2 cycles per neuron with no backpressure. First res_valid appears N_IN+3 cycles after the start cycle.
- w_addr comes from a running counter incremented on each issue and never reset between columns. No multiplier.
- start while busy: ignored. res_ready while !res_valid: ignored.

Decomposition:
- Shared package: FSM state encoding (IDLE, CLR, ACC, DRAIN, CAP, DONE), FP_ZERO constant, and the address-width function.
- One natural sub-module: fc_addr_gen (k/col/weight counters and issue strobe), with the FSM in the top module.
- The PE itself is instantiated in the layer top, not inside this block.

Test Plan:
- N_IN=4, N_OUT=3; inputs 1.0,2.0,3.0,4.0 (3F800000,40000000,40400000,40800000); weights col0 all 1.0, col1 all 2.0, col2 all 0; res_ready=1. Required: res_data 41200000 idx0, 41A00000 idx1, 00000000 idx2; done pulses once.
- Check pe_start_newcol is high exactly in each CLR cycle. Check w_addr sequence 0..11 contiguous, and that no operand is nonzero outside rd_valid_d cycles.
- Hold res_ready=0 after the first result. Required: FSM parks in CAP for col1; res_data stays 41200000. Raise res_ready: 41A00000 is loaded in the same cycle; no lost or duplicated idx.
- N_IN=1, N_OUT=1, input 3.0, weight 2.0. Required: CLR->DRAIN->CAP; res_data 40C00000 at cycle 4 after start.
- Assert rst_n low during ACC of col1. Required: busy/res_valid go 0 immediately. A new start restarts from col0 with correct sums.
- Pulse start while busy. Required: no effect on addresses or results.
